// File: rtl/divider_arb_pkg.sv
// Shared types and constants for the two-requester divider arbiter.
package divider_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;

  // Quotient reported for a bypassed divide-by-zero.
  localparam logic [DATA_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/divider_arbiter_rr.sv
// Two-way round-robin grant: the pointer names the preferred requester,
// otherwise the other requester wins if it is the only one asking.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  logic ptr_alt;

  assign ptr_alt = ~ptr;

  // One-hot grant, preferred requester first.
  always_comb begin
    gnt = 2'b00;
    if (req[ptr]) begin
      gnt[ptr] = 1'b1;
    end else if (req[ptr_alt]) begin
      gnt[ptr_alt] = 1'b1;
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Arbitrates two requesters onto one external signed 32-bit divider.
// Optional feature: define DIV_ZERO_BYPASS_EN to answer divide-by-zero
// requests locally (quotient all ones, remainder = dividend) without
// starting the divider.
module divider_arbiter
  import divider_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_dividend,
  input  logic [63:0] req_divisor,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_quotient,
  output logic [31:0] rsp_remainder,
  output logic        rsp_dbz,
  output logic        rsp_err,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_done,
  output logic        busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_nxt;

  logic                     ptr;
  logic                     own;
  logic [1:0]               gnt;
  logic signed [DATA_W-1:0] sel_dividend, sel_divisor;
  logic signed [DATA_W-1:0] opa, opb, quo, rem;
  logic                     dbz, err;
  logic [CNT_W-1:0]         wait_cnt;
  logic                     accept, bypass, done_ok, timeout, handshake;

  rr_arbiter_2 u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  // Operand mux for the granted requester and per-state event decode.
  always_comb begin
    sel_dividend = gnt[1] ? req_dividend[63:32] : req_dividend[31:0];
    sel_divisor  = gnt[1] ? req_divisor[63:32]  : req_divisor[31:0];
    accept       = (state == IDLE) && (req_valid != 2'b00);
`ifdef DIV_ZERO_BYPASS_EN
    bypass       = (sel_divisor == '0);
`else
    bypass       = 1'b0;
`endif
    // The first WAIT cycle (wait_cnt == 0) blanks a stale done.
    done_ok      = (state == WAIT) && div_done && (wait_cnt != '0);
    timeout      = (state == WAIT) && (wait_cnt == CNT_LAST);
    handshake    = (state == RESP) && rsp_ready[own];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    div_start = 1'b0;
    rsp_valid = 2'b00;
    unique case (state)
      IDLE: begin
        // rst gate keeps req_ready low while reset is asserted.
        if (accept && !rst) req_ready = gnt;
        if (accept) state_nxt = bypass ? RESP : ISSUE;
      end
      ISSUE: begin
        div_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done_ok || timeout) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = own ? 2'b10 : 2'b01;
        if (handshake) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant owner, round-robin pointer and WAIT-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b0;
      own      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (accept)    own <= gnt[1];
      if (handshake) ptr <= ~own;
      if ((state == WAIT) && !done_ok && !timeout) wait_cnt <= wait_cnt + CNT_W'(1);
      else                                         wait_cnt <= '0;
    end
  end

  // Operand latch and response capture; all of these drive outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa <= '0;
      opb <= '0;
      quo <= '0;
      rem <= '0;
      dbz <= 1'b0;
      err <= 1'b0;
    end else if (accept) begin
      opa <= sel_dividend;
      opb <= sel_divisor;
      dbz <= (sel_divisor == '0);
      err <= 1'b0;
      if (bypass) begin
        quo <= DBZ_QUOTIENT;
        rem <= sel_dividend;
      end
    end else if (done_ok) begin
      quo <= div_quotient;
      rem <= div_remainder;
    end else if (timeout) begin
      quo <= '0;
      rem <= '0;
      err <= 1'b1;
    end
  end

  assign div_dividend  = opa;
  assign div_divisor   = opb;
  assign rsp_quotient  = quo;
  assign rsp_remainder = rem;
  assign rsp_dbz       = dbz;
  assign rsp_err       = err;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter with a behavioural divider model.
module tb_divider_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_dividend, req_divisor;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_quotient, rsp_remainder;
  logic        rsp_dbz, rsp_err;
  logic        div_start;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_quotient, div_remainder;
  logic        div_done;
  logic        busy;

  always #5 clk = ~clk;

  divider_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .rsp_err(rsp_err),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_done(div_done), .busy(busy)
  );

`ifdef DIV_ZERO_BYPASS_EN
  localparam int EXP_DBZ_STARTS = 0;
`else
  localparam int EXP_DBZ_STARTS = 1;
`endif

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_start = 0;
  int   cyc_acc = 0, cyc_start = 0, cyc_rsp = 0;
  bit   rsp_prev = 1'b0;
  bit   done_en = 1'b1;
  bit   stale_en = 1'b0;
  int   div_lat = 1;
  bit   hold_valid = 1'b0;
  int   hold_target = 0;
  logic [1:0] drop_mask = 2'b00;

  exp_t mon_e, pop_e;
  logic signed [31:0] mon_a, mon_b;
  int   mon_idx;

  // Divider model: result div_lat cycles after div_start, optional stale pulse.
  logic signed [31:0] m_a, m_b;
  int  m_cnt;
  bit  m_busy;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_done      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
      m_busy        <= 1'b0;
      m_cnt         <= 0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        m_a    <= div_dividend;
        m_b    <= div_divisor;
        m_cnt  <= div_lat - 1;
        m_busy <= 1'b1;
        if (stale_en) begin
          div_done      <= 1'b1;
          div_quotient  <= 32'd12345;
          div_remainder <= 32'd777;
        end
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy   <= 1'b0;
          div_done <= done_en;
          if (m_b == 0) begin
            div_quotient  <= 32'hFFFF_FFFF;
            div_remainder <= m_a;
          end else begin
            div_quotient  <= m_a / m_b;
            div_remainder <= m_a % m_b;
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: push expectations on accept, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst) begin
      rsp_prev = 1'b0;
    end else begin
      if (req_ready != 2'b00) begin
        n_cmp++;
        if (!$onehot(req_ready)) begin
          n_bad++;
          $display("FAIL req_ready_onehot: got %b", req_ready);
        end
        mon_idx = req_ready[1] ? 1 : 0;
        mon_a   = req_dividend[32*mon_idx +: 32];
        mon_b   = req_divisor[32*mon_idx +: 32];
        mon_e.owner = req_ready;
        if (mon_b == 0) begin
          mon_e.q = 32'hFFFF_FFFF; mon_e.r = mon_a; mon_e.dbz = 1'b1; mon_e.err = 1'b0;
`ifndef DIV_ZERO_BYPASS_EN
          if (!done_en) begin mon_e.q = '0; mon_e.r = '0; mon_e.err = 1'b1; end
`endif
        end else if (!done_en) begin
          mon_e.q = '0; mon_e.r = '0; mon_e.dbz = 1'b0; mon_e.err = 1'b1;
        end else begin
          mon_e.q = mon_a / mon_b; mon_e.r = mon_a % mon_b; mon_e.dbz = 1'b0; mon_e.err = 1'b0;
        end
        sb.push_back(mon_e);
        grant_log.push_back(mon_idx);
        cyc_acc   = cyc;
        drop_mask = req_ready;
      end
      if (div_start) begin
        n_start++;
        cyc_start = cyc;
      end
      if ((rsp_valid != 2'b00) && !rsp_prev) cyc_rsp = cyc;
      rsp_prev = (rsp_valid != 2'b00);
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected: rsp_valid %b with empty scoreboard", rsp_valid);
        end else begin
          pop_e = sb.pop_front();
          n_cmp++;
          if (rsp_valid !== pop_e.owner) begin n_bad++; $display("FAIL rsp_owner: got %b want %b", rsp_valid, pop_e.owner); end
          n_cmp++;
          if (rsp_quotient !== pop_e.q) begin n_bad++; $display("FAIL rsp_q: got %h want %h", rsp_quotient, pop_e.q); end
          n_cmp++;
          if (rsp_remainder !== pop_e.r) begin n_bad++; $display("FAIL rsp_r: got %h want %h", rsp_remainder, pop_e.r); end
          n_cmp++;
          if (rsp_dbz !== pop_e.dbz) begin n_bad++; $display("FAIL rsp_dbz: got %b want %b", rsp_dbz, pop_e.dbz); end
          n_cmp++;
          if (rsp_err !== pop_e.err) begin n_bad++; $display("FAIL rsp_err: got %b want %b", rsp_err, pop_e.err); end
        end
      end
    end
  end

  // Requester model: drop (or stop holding) a request after it is accepted,
  // then scramble its operands to show they were latched.
  always @(posedge clk) begin
    #1;
    if (hold_valid) begin
      if (grant_log.size() >= hold_target) req_valid = 2'b00;
    end else if (drop_mask != 2'b00) begin
      req_valid = req_valid & ~drop_mask;
      if (drop_mask[0]) begin req_dividend[31:0]  = $urandom; req_divisor[31:0]  = $urandom; end
      if (drop_mask[1]) begin req_dividend[63:32] = $urandom; req_divisor[63:32] = $urandom; end
    end
    drop_mask = 2'b00;
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_dividend[32*i +: 32] = a;
    req_divisor[32*i +: 32]  = b;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && (req_valid == 2'b00) && (sb.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    req_valid = 2'b11;
    set_req(0, 32'd5, 32'd1);
    set_req(1, 32'd6, 32'd1);
    #23;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_cmp++; if ({div_start, busy, rsp_dbz, rsp_err} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {div_start, busy, rsp_dbz, rsp_err}); end
    n_cmp++; if ({rsp_quotient, rsp_remainder} !== 64'd0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0", {rsp_quotient, rsp_remainder}); end
    n_cmp++; if ({div_dividend, div_divisor} !== 64'd0) begin n_bad++; $display("FAIL reset_div_ops: got %h want 0", {div_dividend, div_divisor}); end
    req_valid = 2'b00;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_same_cycle;
    bit ok;
    int base = grant_log.size();
    @(posedge clk); #2;
    set_req(0, -32'sd7, 32'sd2);
    set_req(1, 32'sd100, -32'sd7);
    req_valid = 2'b11;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL same_cycle_drain: got %b want 1", ok); end
    n_cmp++;
    if (grant_log.size() != base + 2 || grant_log[base] != 0 || grant_log[base+1] != 1) begin
      n_bad++; $display("FAIL same_cycle_order: got %0d grants, first %0d", grant_log.size() - base, (grant_log.size() > base) ? grant_log[base] : -1);
    end
  endtask

  task automatic test_round_robin;
    bit ok;
    int base = grant_log.size();
    @(posedge clk); #2;
    hold_target = base + 4;
    hold_valid  = 1'b1;
    set_req(0, 32'sd40, 32'sd6);
    set_req(1, -32'sd40, 32'sd6);
    req_valid = 2'b11;
    wait_idle(ok);
    hold_valid = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rr_drain: got %b want 1", ok); end
    n_cmp++; if (grant_log.size() != base + 4) begin n_bad++; $display("FAIL rr_count: got %0d want 4", grant_log.size() - base); end
    for (int i = 0; i < 4 && base + i < grant_log.size(); i++) begin
      n_cmp++;
      if (grant_log[base+i] != (i % 2)) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, grant_log[base+i], i % 2); end
    end
  endtask

  task automatic test_single;
    bit ok;
    int n0 = n_start;
    @(posedge clk); #2;
    set_req(0, 32'sd50, 32'sd3);
    req_valid = 2'b01;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_drain: got %b want 1", ok); end
    n_cmp++; if (n_start - n0 != 1) begin n_bad++; $display("FAIL single_starts: got %0d want 1", n_start - n0); end
    n_cmp++; if (cyc_start - cyc_acc != 1) begin n_bad++; $display("FAIL single_start_lat: got %0d want 1", cyc_start - cyc_acc); end
    n_cmp++; if (cyc_rsp - cyc_start != 3) begin n_bad++; $display("FAIL single_rsp_lat: got %0d want 3", cyc_rsp - cyc_start); end
  endtask

  task automatic test_stall;
    bit ok;
    bit seen = 1'b0;
    @(posedge clk); #2;
    rsp_ready = 2'b00;
    set_req(0, 32'sd9, 32'sd4);
    req_valid = 2'b01;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin seen = 1'b1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL stall_rsp_seen: got %b want 1", seen); end
    @(posedge clk); #2;
    set_req(1, 32'sd30, 32'sd7);
    req_valid = req_valid | 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 2'b01 || rsp_quotient !== 32'd2 || rsp_remainder !== 32'd1) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got v=%b q=%h r=%h want 01/2/1", i, rsp_valid, rsp_quotient, rsp_remainder);
      end
      n_cmp++;
      if (req_ready !== 2'b00 || busy !== 1'b1) begin
        n_bad++; $display("FAIL stall_ctrl[%0d]: got ready=%b busy=%b want 00/1", i, req_ready, busy);
      end
    end
    @(posedge clk); #2;
    rsp_ready = 2'b11;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL stall_handshake_ready: got %b want 00", req_ready); end
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_drain: got %b want 1", ok); end
  endtask

  task automatic test_stale_done;
    bit ok;
    @(posedge clk); #2;
    stale_en = 1'b1;
    div_lat  = 3;
    set_req(1, 32'sd20, 32'sd6);
    req_valid = 2'b10;
    wait_idle(ok);
    stale_en = 1'b0;
    div_lat  = 1;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stale_drain: got %b want 1", ok); end
  endtask

  task automatic test_timeout;
    bit ok;
    @(posedge clk); #2;
    done_en = 1'b0;
    set_req(0, 32'sd10, 32'sd5);
    req_valid = 2'b01;
    wait_idle(ok);
    done_en = 1'b1;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL timeout_drain: got %b want 1", ok); end
    n_cmp++; if (cyc_rsp - cyc_start != 65) begin n_bad++; $display("FAIL timeout_wait_cycles: got %0d want 65", cyc_rsp - cyc_start); end
  endtask

  task automatic test_div_zero;
    bit ok;
    int n0 = n_start;
    @(posedge clk); #2;
    set_req(0, 32'sd50, 32'sd0);
    req_valid = 2'b01;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL dbz_drain: got %b want 1", ok); end
    n_cmp++; if (n_start - n0 != EXP_DBZ_STARTS) begin n_bad++; $display("FAIL dbz_starts: got %0d want %0d", n_start - n0, EXP_DBZ_STARTS); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen = 1'b0;
    @(posedge clk); #2;
    done_en = 1'b0;
    set_req(0, 32'sd11, 32'sd3);
    req_valid = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (div_start) begin seen = 1'b1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rstmid_start_seen: got %b want 1", seen); end
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({req_ready, rsp_valid, div_start, busy, rsp_dbz, rsp_err} !== 8'd0) begin
      n_bad++; $display("FAIL rstmid_ctrl: got %b want 0", {req_ready, rsp_valid, div_start, busy, rsp_dbz, rsp_err});
    end
    n_cmp++; if ({rsp_quotient, rsp_remainder, div_dividend, div_divisor} !== 128'd0) begin
      n_bad++; $display("FAIL rstmid_data: got %h want 0", {rsp_quotient, rsp_remainder, div_dividend, div_divisor});
    end
    sb.delete();
    done_en = 1'b1;
    set_req(1, 32'sd77, 32'sd8);
    req_valid = 2'b10;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rstmid_ready_in_reset: got %b want 00", req_ready); end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL rstmid_first_cycle_start: got %b want 0", div_start); end
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL rstmid_first_accept: got %b want 10", req_ready); end
    @(negedge clk);
    n_cmp++; if (div_start !== 1'b1) begin n_bad++; $display("FAIL rstmid_second_cycle_start: got %b want 1", div_start); end
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rstmid_drain: got %b want 1", ok); end
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 2'b00;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 2'b11;
    test_reset();
    test_same_cycle();
    test_round_robin();
    test_single();
    test_stall();
    test_stale_done();
    test_timeout();
    test_div_zero();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL be the maximum number of WAIT cycles before a request is aborted.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-004 Port req_valid, input, 2, SHALL flag a pending request per requester (bit i = requester i).
REQ-005 Port req_ready, output, 2, SHALL pulse one-hot for one cycle when that request is accepted.
REQ-006 Ports req_dividend and req_divisor, input, 64 each, SHALL carry signed 32-bit operands packed as [32*i +: 32].
REQ-007 Port rsp_valid, output, 2, SHALL be one-hot and SHALL mark the owner of the response.
REQ-008 Port rsp_ready, input, 2, SHALL be the per-requester response acceptance.
REQ-009 Ports rsp_quotient and rsp_remainder, output, 32 each, SHALL be signed results.
REQ-010 Ports rsp_dbz and rsp_err, output, 1 each, SHALL flag divide-by-zero and timeout.
REQ-011 Ports div_start (output, 1), div_dividend and div_divisor (output, 32), div_quotient and div_remainder (input, 32), and div_done (input, 1) SHALL drive and observe the shared signed 32-bit divider.
REQ-012 Port busy, output, 1, SHALL be high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-014 IDLE: when any req_valid bit is high, the block SHALL grant one requester, pulse its req_ready, latch its operands and go to ISSUE.
- Grant rule: round-robin. The pointer selects the preferred requester; if only one requester is valid, that requester wins.
REQ-015 ISSUE: div_start SHALL be high for exactly one cycle with the latched operands on div_dividend and div_divisor; the FSM SHALL then go to WAIT.
REQ-016 div_dividend and div_divisor SHALL hold the latched operands from ISSUE until RESP is exited.
REQ-017 WAIT: div_done SHALL be ignored in the first WAIT cycle (blanking for stale done).
- On a later div_done high, the block SHALL capture div_quotient and div_remainder and go to RESP.
REQ-018 WAIT: once TIMEOUT_CYCLES cycles elapse without div_done, the block SHALL go to RESP with quotient 0, remainder 0 and rsp_err=1.
REQ-019 RESP: rsp_valid[g] and all response data SHALL stay stable until rsp_ready[g] is high.
- On that handshake the pointer SHALL move to the other requester and the FSM SHALL return to IDLE.
- No request SHALL be accepted during the handshake cycle.
REQ-020 rsp_dbz SHALL equal (latched divisor == 0) for every response.
REQ-021 Minimum latency (no bypass) SHALL be: accept at cycle N, div_start at N+1, rsp_valid at the cycle after the sampled div_done.
REQ-022 req_ready, div_start and rsp_valid SHALL never be high for a requester or transaction other than the current grant.
- Changes on req_valid and operands after acceptance SHALL NOT affect the transaction in flight.

Reset
REQ-023 While rst is high, the following SHALL be 0 regardless of clk:
- all outputs;
- the round-robin pointer (requester 0 preferred);
- the timeout counter.
REQ-024 While rst is high, the FSM SHALL be in IDLE.
REQ-025 A reset mid-operation SHALL abandon the transaction with no response, and no div_start SHALL be issued in the first cycle after reset release.

Configuration
REQ-026 When macro DIV_ZERO_BYPASS_EN is defined, a request accepted with divisor 0 SHALL skip ISSUE and WAIT.
- The FSM SHALL go directly to RESP with quotient 32'hFFFFFFFF, remainder = dividend and rsp_dbz=1.
- No div_start SHALL be issued.
REQ-027 When DIV_ZERO_BYPASS_EN is undefined, divisor 0 SHALL be forwarded to the divider like any other request; the result SHALL come from the divider, with rsp_dbz=1.

Structure
REQ-028 Package divider_arb_pkg SHALL hold:
- the FSM state enum;
- constants NUM_REQ=2 and DATA_W=32;
- DBZ_QUOTIENT=32'hFFFFFFFF.
REQ-029 Grant selection SHALL be a sub-module rr_arbiter_2 (inputs: request vector, pointer; output: one-hot grant).
REQ-030 The divider SHALL NOT be instantiated inside divider_arbiter; it SHALL be connected at the parent level.

Verification
REQ-031 req0 50/3 alone -> exactly one div_start, then rsp_valid=2'b01 with q=16, r=2, dbz=0, err=0.
REQ-032 req0 -7/2 and req1 100/-7 raised in the same cycle after reset -> req0 served first (q=-3, r=-1), then req1 (q=-14, r=2).
REQ-033 Both requesters held valid for 4 transactions -> grant order 0,1,0,1.
REQ-034 rsp_ready held low 5 cycles in RESP -> rsp_valid and data stable, req_ready stays 0, busy=1.
REQ-035 50/0 -> with DIV_ZERO_BYPASS_EN: no div_start, q=FFFFFFFF, r=50, dbz=1; without the macro: div_start issued, dbz=1.
REQ-036 div_done tied low -> rsp_err=1, q=0, r=0 after 64 WAIT cycles; a separate run asserts rst mid-WAIT -> all outputs 0 and busy=0 immediately.
